fifo_data: RTL and testbench

- Synchronous single-clock first-in/first-out buffer for 32-bit data words.
- Decouples a word producer from a consumer (for example, cipher data input/output staging in the AES core datapath).
- Write and read are single-cycle strobes.
- Read data is registered; status flags (full, empty, count, overflow, underflow) are provided for flow control.

---
 rtl/fifo_data.sv | 77 +++++++
 tb/tb_fifo_data.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fifo_data.sv
// rtl/fifo_data.sv - single-clock 32-bit word FIFO with registered read data and status flags
module fifo_data #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  write_fifo,
    input  logic                  read_fifo,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_rd_ok;
    logic w_wr_ok;

    assign full  = (r_count == L_DEPTH);
    assign empty = (r_count == '0);

    // A read frees a slot this cycle, so a write into a full FIFO still lands.
    assign w_rd_ok = read_fifo & ~empty;
    assign w_wr_ok = write_fifo & (~full | w_rd_ok);

    always_ff @(posedge clk) begin
        if (w_wr_ok && !resetn) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= r_mem[r_rd_ptr];
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow  <= write_fifo & ~w_wr_ok;
            r_underflow <= read_fifo & ~w_rd_ok;
        end
    end

    assign data_out  = r_data_out;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_fifo_data.sv
// tb/tb_fifo_data.sv - self-checking bench for fifo_data against a queue reference model
module tb_fifo_data;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          write_fifo = 1'b0;
    logic          read_fifo = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    fifo_data #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .write_fifo (write_fifo),
        .read_fifo  (read_fifo),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"},     32'(count),     32'(q.size()));
        chk({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
        chk({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
        chk({tag, ".data_out"},  data_out,       m_dout);
        chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    // Called at a negedge: apply strobes, advance the model at the posedge, check at the next negedge.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        logic rd_ok;
        logic wr_ok;
        write_fifo = w;
        read_fifo  = r;
        data_in    = d;
        @(posedge clk);
        rd_ok = r && (q.size() > 0);
        wr_ok = w && ((q.size() < DEPTH) || rd_ok);
        m_ovf = w && !wr_ok;
        m_unf = r && !rd_ok;
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
        @(negedge clk);
        write_fifo = 1'b0;
        read_fifo  = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    initial begin
        // Power-on reset held for two cycles
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        model_reset();
        check_all("reset");
        chk("reset.dout_const", data_out, 32'h0000_0000);

        // Writes with a gap, reads, holds
        step(1'b1, 1'b0, 32'hAAAA_AAAA, "wr_a");
        step(1'b0, 1'b0, 32'h0,         "gap");
        step(1'b1, 1'b0, 32'hBBBB_BBBB, "wr_b");
        step(1'b1, 1'b0, 32'hCCCC_CCCC, "wr_c");
        step(1'b1, 1'b0, 32'hDDDD_DDDD, "wr_d");
        step(1'b1, 1'b0, 32'hEEEE_EEEE, "wr_e");
        chk("five.count_const", 32'(count), 32'd5);
        step(1'b0, 1'b1, 32'hEEEE_EEEE, "rd_1");
        chk("rd_1.const", data_out, 32'hAAAA_AAAA);
        step(1'b0, 1'b1, 32'hEEEE_EEEE, "rd_2");
        chk("rd_2.const", data_out, 32'hBBBB_BBBB);
        step(1'b1, 1'b0, 32'hEEEE_EEEE, "wr_e2");
        step(1'b0, 1'b1, 32'h0, "rd_3");
        step(1'b0, 1'b1, 32'h0, "rd_4");
        chk("rd_4.const", data_out, 32'hDDDD_DDDD);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, "hold");
        step(1'b0, 1'b1, 32'h0, "drain_a");
        step(1'b0, 1'b1, 32'h0, "drain_b");

        // Fill to DEPTH, overflow, drain, underflow
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 32'(i), "fill");
        step(1'b1, 1'b0, 32'h9, "overflow");
        chk("overflow.const", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'h0, "drain");
        step(1'b0, 1'b1, 32'h0, "underflow");
        chk("underflow.dout_const", data_out, 32'h8);

        // Pointer wrap-around
        for (int rnd = 0; rnd < 4; rnd++) begin
            for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom, "wrap_wr");
            for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0, "wrap_rd");
        end

        // Simultaneous read+write when empty, then when full
        step(1'b1, 1'b1, 32'h5555_0001, "rw_empty");
        for (int i = 2; i <= DEPTH; i++) step(1'b1, 1'b0, 32'h5555_0000 + 32'(i), "refill");
        step(1'b1, 1'b1, 32'h6666_6666, "rw_full");
        chk("rw_full.dout_const", data_out, 32'h5555_0001);

        // Asynchronous reset between clock edges with five words queued
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'h0, "pre_rst_drain");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, $urandom, "pre_rst_fill");
        #2 resetn = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk);
        resetn = 1'b0;
        step(1'b1, 1'b0, 32'h1234_5678, "post_rst_wr");
        step(1'b0, 1'b1, 32'h0, "post_rst_rd");
        chk("post_rst.const", data_out, 32'h1234_5678);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom, "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
